hqm_list_sel_pipe_qid2cqidx_cfg_ctrl: RTL

Config-side controller for the packed 512-entry x 8b (+parity) qid2cqidx RAM. It initializes all entries after reset, serializes config byte writes and reads onto the RAM port, generates write parity and checks read parity. It also asserts a read-block to the list_sel pipeline for every write window: write cycle + 2, as the packed RAM requires for its read-modify-write. It sits between the CFG register interface and the packed RAM, in the list_sel pipe clock domain.

---
 rtl/hqm_list_sel_pipe_qid2cqidx_cfg_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/hqm_list_sel_pipe_qid2cqidx_cfg_ctrl.sv
// Purpose : config-side controller for the packed 512x8b(+parity) qid2cqidx RAM:
//           init sweep, serialized cfg byte write/read, parity gen/check, pipe read-block.
// Latency : write accepted at T -> ram_we T+1, rsp T+4; read accepted at T -> ram_re T+1, rsp T+3.
// Backpr. : cfg_req_ready only in IDLE; cfg_rsp has no backpressure; pipe reads are
//           dropped while pipe_rd_block is high.
//
// Ports:
//   clk, rst_n                        pipe clock, async active-low reset
//   cfg_req_*_i / cfg_req_ready_o     config request (valid/ready)
//   cfg_rsp_*_o                       one-cycle response pulse with read byte / parity error
//   par_err_cnt_o, init_done_o        saturating error count, sticky init-complete
//   pipe_re_i, pipe_raddr_i           list_sel pipeline read request
//   pipe_rd_block_o, pipe_par_err_o   pipeline read-block, pipeline parity error pulse
//   ram_*                             packed RAM write/read port
//
// Build option: define HQM_LSP_QID2CQIDX_PIPE_PAR_CHK_EN to parity-check pipeline reads
// (pipe_par_err_o pulses two cycles after the read and the error counter includes them).
// Without it pipe_par_err_o is tied low.
module hqm_list_sel_pipe_qid2cqidx_cfg_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req_v_i,
  output logic       cfg_req_ready_o,
  input  logic       cfg_req_write_i,
  input  logic [8:0] cfg_req_addr_i,
  input  logic [7:0] cfg_req_wdata_i,
  output logic       cfg_rsp_v_o,
  output logic [7:0] cfg_rsp_rdata_o,
  output logic       cfg_rsp_par_err_o,
  output logic [7:0] par_err_cnt_o,
  output logic       init_done_o,
  input  logic       pipe_re_i,
  input  logic [8:0] pipe_raddr_i,
  output logic       pipe_rd_block_o,
  output logic       pipe_par_err_o,
  output logic       ram_we_o,
  output logic [8:0] ram_waddr_o,
  output logic [7:0] ram_wdata_o,
  output logic       ram_wdata_parity_o,
  output logic       ram_re_o,
  output logic [8:0] ram_raddr_o,
  input  logic [7:0] ram_rdata_i,
  input  logic       ram_rdata_parity_i
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WR, ST_RD} state_e;

  state_e     state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [8:0] icnt_q, icnt_d;
  logic [8:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       init_done_q, init_done_d;
  logic       rd_cap_q;
  logic       rsp_v_q, rsp_v_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_par_err_q;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic is_idle, cfg_acc, pipe_issue, rd_par_bad, cfg_err, pipe_err;

  assign is_idle         = (state_q == ST_IDLE);
  assign cfg_acc         = is_idle & cfg_req_v_i;
  assign cfg_req_ready_o = is_idle;
  assign pipe_rd_block_o = ~is_idle;
  assign pipe_issue      = is_idle & pipe_re_i;

  // RAM write port: init sweep writes zero to icnt, cfg write uses latched addr/data.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_waddr_o = 9'd0;
    ram_wdata_o = 8'd0;
    if (wcnt_q == 2'd0) begin
      if (state_q == ST_INIT) begin
        ram_we_o    = 1'b1;
        ram_waddr_o = icnt_q;
      end else if (state_q == ST_WR) begin
        ram_we_o    = 1'b1;
        ram_waddr_o = addr_q;
        ram_wdata_o = data_q;
      end
    end
  end
  assign ram_wdata_parity_o = ^ram_wdata_o;

  // RAM read port: the config read owns the port in RD, otherwise pass pipe reads through.
  assign ram_re_o    = pipe_issue | (state_q == ST_RD);
  assign ram_raddr_o = (state_q == ST_RD) ? addr_q : (pipe_issue ? pipe_raddr_i : 9'd0);

  assign rd_par_bad = ^{ram_rdata_i, ram_rdata_parity_i};
  assign cfg_err    = rd_cap_q & rd_par_bad;

`ifdef HQM_LSP_QID2CQIDX_PIPE_PAR_CHK_EN
  logic pipe_chk_q, pipe_par_err_q;
  assign pipe_err       = pipe_chk_q & rd_par_bad;
  assign pipe_par_err_o = pipe_par_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_chk_q     <= 1'b0;
      pipe_par_err_q <= 1'b0;
    end else begin
      pipe_chk_q     <= pipe_issue;
      pipe_par_err_q <= pipe_err;
    end
  end
`else
  assign pipe_err       = 1'b0;
  assign pipe_par_err_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    icnt_d      = icnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        // wcnt resets to 3 so the cycle right after reset release is a dead cycle.
        if (wcnt_q == 2'd3) begin
          wcnt_d = 2'd0;
        end else if (wcnt_q == 2'd2) begin
          wcnt_d = 2'd0;
          icnt_d = icnt_q + 9'd1;
          if (icnt_q == 9'd511) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      ST_IDLE: begin
        if (cfg_acc) begin
          addr_d = cfg_req_addr_i;
          wcnt_d = 2'd0;
          if (cfg_req_write_i) begin
            data_d  = cfg_req_wdata_i;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (wcnt_q == 2'd2) begin
          wcnt_d  = 2'd0;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE; // ST_RD lasts one cycle
    endcase
  end

  // Write response after the hold window; read response one cycle after the RAM returns data.
  assign rsp_v_d     = ((state_q == ST_WR) && (wcnt_q == 2'd2)) | rd_cap_q;
  assign rsp_rdata_d = rd_cap_q ? ram_rdata_i : 8'd0;
  assign err_cnt_d   = ((cfg_err | pipe_err) && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      wcnt_q        <= 2'd3;
      icnt_q        <= 9'd0;
      addr_q        <= 9'd0;
      data_q        <= 8'd0;
      init_done_q   <= 1'b0;
      rd_cap_q      <= 1'b0;
      rsp_v_q       <= 1'b0;
      rsp_rdata_q   <= 8'd0;
      rsp_par_err_q <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      icnt_q        <= icnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      init_done_q   <= init_done_d;
      rd_cap_q      <= (state_q == ST_RD);
      rsp_v_q       <= rsp_v_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_par_err_q <= cfg_err;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign cfg_rsp_v_o       = rsp_v_q;
  assign cfg_rsp_rdata_o   = rsp_rdata_q;
  assign cfg_rsp_par_err_o = rsp_par_err_q;
  assign par_err_cnt_o     = err_cnt_q;
  assign init_done_o       = init_done_q;

endmodule
